// File: rtl/glyph_serializer_pkg.sv
// Shared geometry, ASCII bounds and FSM encoding for the glyph serializer
// and its scan counter.
package glyph_serializer_pkg;

  localparam int GLYPH_COLS = 5;
  localparam int GLYPH_ROWS = 7;
  localparam int GLYPH_BITS = GLYPH_COLS * GLYPH_ROWS;
  localparam int ASCII_MIN  = 32;
  localparam int ASCII_MAX  = 126;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/glyph_serializer_scan_counter.sv
// Row/column scan counter for one glyph: logical LED index, bitmap source
// position (with optional serpentine column flip) and last-pixel flag.
module glyph_scan_counter
  import glyph_serializer_pkg::*;
#(
  parameter int COLS       = GLYPH_COLS,
  parameter int ROWS       = GLYPH_ROWS,
  parameter int SERPENTINE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [5:0] index,
  output logic [5:0] src_pos,
  output logic       last
);

  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] src_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row   <= '0;
      col   <= '0;
      index <= '0;
    end else if (clear) begin
      row   <= '0;
      col   <= '0;
      index <= '0;
    end else if (advance) begin
      // Wrap to zero after the final pixel so an idle block shows index 0.
      if (last) begin
        row   <= '0;
        col   <= '0;
        index <= '0;
      end else begin
        index <= index + 6'd1;
        if (col == 3'(COLS - 1)) begin
          col <= '0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  assign last    = (row == 3'(ROWS - 1)) && (col == 3'(COLS - 1));
  assign src_col = ((SERPENTINE != 0) && row[0]) ? (3'(COLS - 1) - col) : col;
  assign src_pos = 6'(row) * 6'(COLS) + 6'(src_col);

endmodule

// File: rtl/glyph_serializer.sv
// Accepts one ASCII code, fetches its 5x7 bitmap from the character ROM and
// streams it out one pixel per accepted beat in LED wiring order.
module glyph_serializer
  import glyph_serializer_pkg::*;
#(
  parameter int COLS       = GLYPH_COLS,
  parameter int ROWS       = GLYPH_ROWS,
  parameter int DATA_WIDTH = GLYPH_BITS,
  parameter int SERPENTINE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [7:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  pix_out,
  output logic [5:0]            pix_index,
  output logic                  pix_last,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy
);

  state_t                state;
  logic [DATA_WIDTH-1:0] bitmap;
  logic [5:0]            scan_index;
  logic [5:0]            src_pos;
  logic [5:0]            bit_sel;
  logic                  scan_last;
  logic                  beat;

  assign beat = (state == SHIFT) && pix_ready;

  glyph_scan_counter #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .SERPENTINE (SERPENTINE)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == LOAD),
    .advance (beat),
    .index   (scan_index),
    .src_pos (src_pos),
    .last    (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      bitmap   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            rom_addr <= char_in;
            state    <= LOAD;
          end
        end
        // rom_addr settled last edge, so the ROM output is valid here.
        LOAD: begin
          bitmap <= rom_data;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready && scan_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bitmap is stored MSB-first: bit DATA_WIDTH-1 is the top-left pixel.
  assign bit_sel    = 6'(DATA_WIDTH - 1) - src_pos;
  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign pix_valid  = (state == SHIFT);
  assign pix_out    = pix_valid & bitmap[bit_sel];
  assign pix_index  = pix_valid ? scan_index : 6'd0;
  assign pix_last   = pix_valid & scan_last;

endmodule

// File: tb/tb_glyph_serializer.sv
// Directed bench for glyph_serializer: expected pixel streams are queued when
// a code is sent and popped as beats are accepted.
module tb_glyph_serializer;

  typedef struct {
    logic       pix;
    logic [5:0] idx;
    logic       last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic [34:0] rom_stub;
  logic        pix_ready;
  logic        sel_serp;

  logic        cr0, cr1, po0, po1, pl0, pl1, pv0, pv1, bz0, bz1;
  logic [7:0]  ra0, ra1;
  logic [5:0]  pi0, pi1;

  logic        char_ready_o, pix_out_o, pix_last_o, pix_valid_o, busy_o;
  logic [7:0]  rom_addr_o;
  logic [5:0]  pix_index_o;

  int checks   = 0;
  int failures = 0;
  beat_t sb[$];

  glyph_serializer #(.SERPENTINE(0)) dut0 (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(cr0), .rom_addr(ra0), .rom_data(rom_stub), .pix_out(po0),
    .pix_index(pi0), .pix_last(pl0), .pix_valid(pv0), .pix_ready(pix_ready),
    .busy(bz0)
  );

  glyph_serializer #(.SERPENTINE(1)) dut1 (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(cr1), .rom_addr(ra1), .rom_data(rom_stub), .pix_out(po1),
    .pix_index(pi1), .pix_last(pl1), .pix_valid(pv1), .pix_ready(pix_ready),
    .busy(bz1)
  );

  assign char_ready_o = sel_serp ? cr1 : cr0;
  assign rom_addr_o   = sel_serp ? ra1 : ra0;
  assign pix_out_o    = sel_serp ? po1 : po0;
  assign pix_index_o  = sel_serp ? pi1 : pi0;
  assign pix_last_o   = sel_serp ? pl1 : pl0;
  assign pix_valid_o  = sel_serp ? pv1 : pv0;
  assign busy_o       = sel_serp ? bz1 : bz0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_char_ready"}, 64'(char_ready_o), 64'd1);
    check({tag, "_pix_valid"},  64'(pix_valid_o),  64'd0);
    check({tag, "_busy"},       64'(busy_o),       64'd0);
    check({tag, "_pix_index"},  64'(pix_index_o),  64'd0);
    check({tag, "_pix_out"},    64'(pix_out_o),    64'd0);
    check({tag, "_pix_last"},   64'(pix_last_o),   64'd0);
  endtask

  // Sends one code and consumes the whole glyph; bp enables random stalls and
  // a competing char_valid while the glyph is in flight.
  task automatic run_glyph(input string tag, input logic [7:0] code, input logic [34:0] bmp,
                           input bit serp, input bit bp);
    beat_t      b;
    int         lat, beats, cyc, r, c, sc;
    bit         stalled;
    logic       s_out, s_last;
    logic [5:0] s_idx;
    sel_serp = serp;
    rom_stub = bmp;
    sb.delete();
    for (int k = 0; k < 35; k++) begin
      r = k / 5;
      c = k % 5;
      sc = (serp && (r % 2 == 1)) ? 4 - c : c;
      b.pix  = bmp[34 - (r * 5 + sc)];
      b.idx  = 6'(k);
      b.last = (k == 34);
      sb.push_back(b);
    end
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(char_ready_o), 64'd1);
    char_in    = code;
    char_valid = 1'b1;
    pix_ready  = 1'b0;
    @(negedge clk);
    char_valid = bp;
    char_in    = 8'hEE;
    check({tag, "_rom_addr"}, 64'(rom_addr_o), 64'(code));
    lat = 1;
    while (!pix_valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    rom_stub = ~bmp;
    stalled = 1'b0;
    beats = 0;
    cyc = 0;
    s_out = 1'b0; s_idx = '0; s_last = 1'b0;
    while (sb.size() > 0 && cyc < 400) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, 64'(pix_valid_o), 64'd1);
        check({tag, "_stall_out"},   64'(pix_out_o),   64'(s_out));
        check({tag, "_stall_index"}, 64'(pix_index_o), 64'(s_idx));
        check({tag, "_stall_last"},  64'(pix_last_o),  64'(s_last));
      end
      if (bp) check({tag, "_busy_not_ready"}, 64'(char_ready_o), 64'd0);
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid_o && pix_ready) begin
        b = sb.pop_front();
        check({tag, "_pix_out"},   64'(pix_out_o),   64'(b.pix));
        check({tag, "_pix_index"}, 64'(pix_index_o), 64'(b.idx));
        check({tag, "_pix_last"},  64'(pix_last_o),  64'(b.last));
        beats++;
        stalled = 1'b0;
        if (sb.size() == 0) char_valid = 1'b0;
      end else begin
        stalled = pix_valid_o;
        s_out = pix_out_o; s_idx = pix_index_o; s_last = pix_last_o;
      end
      @(negedge clk);
      cyc++;
    end
    char_valid = 1'b0;
    pix_ready  = 1'b0;
    check({tag, "_beats"}, 64'(beats), 64'd35);
    check_idle({tag, "_after"});
    check({tag, "_rom_addr_held"}, 64'(rom_addr_o), 64'(code));
  endtask

  initial begin
    int cyc, acc1, acc2, beats;
    logic [63:0] rnd;
    reset = 1'b1; char_in = '0; char_valid = 1'b0; pix_ready = 1'b0;
    rom_stub = '0; sel_serp = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_rom_addr", 64'(rom_addr_o), 64'd0);

    run_glyph("basic", 8'h41, 35'h4_0000_0001, 1'b0, 1'b0);
    run_glyph("serp", 8'h42, 35'h0_2000_0000, 1'b1, 1'b0);
    rnd = {$urandom(), $urandom()};
    run_glyph("bp", 8'h33, rnd[34:0], 1'b0, 1'b1);
    rnd = {$urandom(), $urandom()};
    run_glyph("bp_serp", 8'h5A, rnd[34:0], 1'b1, 1'b1);

    // Back-to-back codes with char_valid held high throughout.
    sel_serp = 1'b0;
    rom_stub = 35'h7_0F0F_0F0F;
    pix_ready = 1'b1;
    @(negedge clk);
    char_in = 8'h20;
    char_valid = 1'b1;
    cyc = 0; acc1 = -1; acc2 = -1; beats = 0;
    while (acc2 < 0 && cyc < 200) begin
      if (char_ready_o && char_valid) begin
        if (acc1 < 0) acc1 = cyc;
        else acc2 = cyc;
      end
      if (pix_valid_o && pix_ready) beats++;
      @(negedge clk);
      cyc++;
      if (acc1 >= 0) char_in = 8'h7E;
    end
    char_valid = 1'b0;
    check("b2b_second_seen", 64'(acc2 >= 0), 64'd1);
    check("b2b_gap", 64'(acc2 - acc1), 64'd37);
    check("b2b_beats", 64'(beats), 64'd35);
    check("b2b_rom_addr", 64'(rom_addr_o), 64'h7E);
    cyc = 0;
    while (busy_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_drain", 64'(busy_o), 64'd0);
    pix_ready = 1'b0;

    // Reset in the middle of a glyph.
    rom_stub = 35'h5_5555_5555;
    pix_ready = 1'b1;
    @(negedge clk);
    char_in = 8'h55;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    cyc = 0;
    while (!(pix_valid_o && pix_index_o == 6'd17) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_17", 64'(pix_index_o), 64'd17);
    reset = 1'b1;
    #1;
    check_idle("rst_mid");
    check("rst_mid_rom_addr", 64'(rom_addr_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    run_glyph("post_rst", 8'h61, 35'h1_2345_6789, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
